// File: rtl/gol_pattern_loader.sv
// Byte-stream command parser that writes cell values into both Game of Life RAM banks
// through the engine's port-B path, holding the engine paused for each write burst.
module gol_pattern_loader #(
    parameter int ADDR_W = 16,
    parameter int CELL_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_hold_req,
    input  logic              i_hold_ack,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we0,
    output logic              o_we1,
    output logic [CELL_W-1:0] o_din,
    output logic              o_busy,
    output logic [7:0]        o_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG1,
        S_ARG2,
        S_REQ,
        S_WRITE
    } state_t;

    localparam logic [7:0]  OP_SET_ADDR   = 8'h01;
    localparam logic [7:0]  OP_WRITE_RUN  = 8'h02;
    localparam logic [7:0]  OP_CLEAR      = 8'h03;
    localparam logic [7:0]  OP_WRITE_CELL = 8'h04;
    localparam logic [16:0] REM_ONE       = 17'd1;
    localparam logic [16:0] REM_RUN_MAX   = 17'd256;
    localparam logic [16:0] REM_CLEAR     = 17'h10000;

    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          r_opcode;
    logic [7:0]          r_arg1;
    logic [ADDR_W-1:0]   r_cursor;
    logic [16:0]         r_remain;
    logic [CELL_W-1:0]   r_value;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [CELL_W-1:0]   r_din;
    logic                r_hold_req;
    logic                r_busy;
    logic [7:0]          r_err_cnt;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_do_write;

    // in_ready is the only combinational output; it is forced low while reset is held.
    assign w_in_ready = i_rst_n &&
                        ((r_state == S_IDLE) || (r_state == S_ARG1) || (r_state == S_ARG2));
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_do_write = ((r_state == S_REQ) && i_hold_ack) ||
                        ((r_state == S_WRITE) && (r_remain != 17'd0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_in_data)
                        OP_SET_ADDR, OP_WRITE_RUN, OP_WRITE_CELL: w_next_state = S_ARG1;
                        OP_CLEAR:                                 w_next_state = S_REQ;
                        default:                                  w_next_state = S_IDLE;
                    endcase
                end
            end
            S_ARG1: begin
                if (w_accept) begin
                    w_next_state = (r_opcode == OP_WRITE_CELL) ? S_REQ : S_ARG2;
                end
            end
            S_ARG2: begin
                if (w_accept) begin
                    w_next_state = (r_opcode == OP_SET_ADDR) ? S_IDLE : S_REQ;
                end
            end
            S_REQ: begin
                if (i_hold_ack) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_remain == 17'd0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // The first write is issued on the edge that samples hold_ack in REQ, so the
    // remaining count reaching zero in WRITE means the burst has finished.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opcode   <= 8'd0;
            r_arg1     <= 8'd0;
            r_cursor   <= '0;
            r_remain   <= 17'd0;
            r_value    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_hold_req <= 1'b0;
            r_busy     <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_we       <= w_do_write;
            r_hold_req <= (w_next_state == S_REQ) || (w_next_state == S_WRITE);
            r_busy     <= (w_next_state != S_IDLE);
            if (w_do_write) begin
                r_addr   <= r_cursor;
                r_din    <= r_value;
                r_cursor <= r_cursor + 1'b1;
                r_remain <= r_remain - 17'd1;
            end else if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        r_opcode <= i_in_data;
                        if (i_in_data == OP_CLEAR) begin
                            r_remain <= REM_CLEAR;
                            r_value  <= '0;
                            r_cursor <= '0;
                        end else if ((i_in_data != OP_SET_ADDR) &&
                                     (i_in_data != OP_WRITE_RUN) &&
                                     (i_in_data != OP_WRITE_CELL) &&
                                     (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                    S_ARG1: begin
                        r_arg1 <= i_in_data;
                        if (r_opcode == OP_WRITE_CELL) begin
                            r_value  <= i_in_data[CELL_W-1:0];
                            r_remain <= REM_ONE;
                        end
                    end
                    S_ARG2: begin
                        if (r_opcode == OP_SET_ADDR) begin
                            r_cursor <= ADDR_W'({i_in_data, r_arg1});
                        end else begin
                            r_value  <= i_in_data[CELL_W-1:0];
                            r_remain <= (r_arg1 == 8'd0) ? REM_RUN_MAX : {9'd0, r_arg1};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_hold_req = r_hold_req;
    assign o_addr     = r_addr;
    assign o_we0      = r_we;
    assign o_we1      = r_we;
    assign o_din      = r_din;
    assign o_busy     = r_busy;
    assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gol_pattern_loader.sv
// Scoreboard bench for gol_pattern_loader: expected writes are queued as commands are
// sent and checked by a negedge monitor as the loader emits them.
module tb_gol_pattern_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_data = 8'd0;
    logic        o_in_ready;
    logic        o_hold_req;
    logic        i_hold_ack = 1'b0;
    logic [15:0] o_addr;
    logic        o_we0;
    logic        o_we1;
    logic [4:0]  o_din;
    logic        o_busy;
    logic [7:0]  o_err_cnt;

    always #5 i_clk = ~i_clk;

    gol_pattern_loader #(.ADDR_W(16), .CELL_W(5)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_in_valid (i_in_valid),
        .i_in_data  (i_in_data),
        .o_in_ready (o_in_ready),
        .o_hold_req (o_hold_req),
        .i_hold_ack (i_hold_ack),
        .o_addr     (o_addr),
        .o_we0      (o_we0),
        .o_we1      (o_we1),
        .o_din      (o_din),
        .o_busy     (o_busy),
        .o_err_cnt  (o_err_cnt)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [20:0] exp_q[$];
    int          len_q[$];
    logic [15:0] model_cursor = 16'd0;

    // Engine model: acknowledges ack_delay cycles after hold_req, drops with hold_req.
    bit ack_tied = 1'b0;
    int ack_delay = 2;
    int ack_cnt = 0;
    always @(posedge i_clk) begin
        #1;
        if (ack_tied) begin
            i_hold_ack = 1'b1;
        end else if (!o_hold_req) begin
            i_hold_ack = 1'b0;
            ack_cnt = 0;
        end else if (ack_cnt >= ack_delay) begin
            i_hold_ack = 1'b1;
        end else begin
            ack_cnt++;
        end
    end

    bit          sb_off = 1'b0;
    bit          prev_we = 1'b0;
    bit          prev_hold = 1'b0;
    bit          grant_seen = 1'b0;
    int          grant_neg = 0;
    int          neg_n = 0;
    int          run_len = 0;
    int          hold_rises = 0;
    logic [20:0] exp_w;
    int          exp_len;

    always @(negedge i_clk) begin
        if (sb_off || !i_rst_n) begin
            prev_we = 1'b0;
            run_len = 0;
            grant_seen = 1'b0;
            prev_hold = 1'b0;
            if (sb_off) begin
                exp_q.delete();
                len_q.delete();
            end
        end else begin
            neg_n++;
            n_checks++;
            if (o_we0 !== o_we1) $display("FAIL we_match: we0=%b we1=%b", o_we0, o_we1);
            else n_pass++;
            if (o_we0) begin
                if (!prev_we) begin
                    n_checks++;
                    if (neg_n !== grant_neg + 1)
                        $display("FAIL start_latency: first we at %0d, expected %0d", neg_n, grant_neg + 1);
                    else n_pass++;
                end
                n_checks++;
                if ({o_in_ready, o_hold_req, o_busy, i_hold_ack} !== 4'b0111)
                    $display("FAIL write_ctrl: in_ready/hold_req/busy/ack=%b expected 0111",
                             {o_in_ready, o_hold_req, o_busy, i_hold_ack});
                else n_pass++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: addr=%h din=%h, no write expected", o_addr, o_din);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({o_addr, o_din} !== exp_w)
                        $display("FAIL write_data: addr=%h din=%h expected addr=%h din=%h",
                                 o_addr, o_din, exp_w[20:5], exp_w[4:0]);
                    else n_pass++;
                end
                run_len++;
            end else if (prev_we) begin
                exp_len = (len_q.size() != 0) ? len_q.pop_front() : -1;
                n_checks++;
                if (run_len !== exp_len) $display("FAIL run_length: got %0d expected %0d", run_len, exp_len);
                else n_pass++;
                n_checks++;
                if ({o_hold_req, o_busy, o_in_ready} !== 3'b001)
                    $display("FAIL after_last: hold_req/busy/in_ready=%b expected 001",
                             {o_hold_req, o_busy, o_in_ready});
                else n_pass++;
                run_len = 0;
            end
            if (o_hold_req && !prev_hold) hold_rises++;
            if (!o_hold_req) grant_seen = 1'b0;
            else if (i_hold_ack && !grant_seen) begin
                grant_seen = 1'b1;
                grant_neg = neg_n;
            end
            prev_hold = o_hold_req;
            prev_we = o_we0;
        end
    end

    task automatic push_run(input logic [15:0] start, input int n, input logic [4:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back({16'(start + 16'(i)), v});
        len_q.push_back(n);
        model_cursor = 16'(start + 16'(n));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge i_clk);
        i_in_valid = 1'b1;
        i_in_data = b;
        while (!o_in_ready && t < 70000) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 70000) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stuck at 0 for byte %h", b);
        end
        @(posedge i_clk);
        #1 i_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((o_busy || exp_q.size() != 0) && t < 70000) begin
            @(negedge i_clk);
            t++;
        end
        n_checks++;
        if (t >= 70000) $display("FAIL %s_idle_timeout: busy=%b pending=%0d", name, o_busy, exp_q.size());
        else n_pass++;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic set_addr(input logic [7:0] x, input logic [7:0] y);
        send_byte(8'h01);
        send_byte(x);
        send_byte(y);
        model_cursor = {y, x};
    endtask

    task automatic write_run(input logic [7:0] n, input logic [7:0] v);
        push_run(model_cursor, (n == 8'd0) ? 256 : int'(n), v[4:0]);
        send_byte(8'h02);
        send_byte(n);
        send_byte(v);
    endtask

    task automatic write_cell(input logic [7:0] v);
        push_run(model_cursor, 1, v[4:0]);
        send_byte(8'h04);
        send_byte(v);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if ({o_hold_req, o_we0, o_we1, o_addr, o_din, o_busy, o_err_cnt, o_in_ready} !== 35'd0)
            $display("FAIL reset_outputs: hold=%b we=%b%b addr=%h din=%h busy=%b err=%0d rdy=%b, expected all 0",
                     o_hold_req, o_we0, o_we1, o_addr, o_din, o_busy, o_err_cnt, o_in_ready);
        else n_pass++;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", o_in_ready);
        else n_pass++;
        write_cell(8'h05);
        wait_idle("reset_cursor");
    endtask

    task automatic test_set_cell;
        ack_tied = 1'b1;
        set_addr(8'h10, 8'h20);
        write_cell(8'hFF);
        wait_idle("set_cell");
        ack_tied = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_back_to_back;
        set_addr(8'hFE, 8'hFF);
        write_run(8'd4, 8'hE3);
        write_cell(8'h11);
        wait_idle("run_wrap");
    endtask

    task automatic test_run256_delayed;
        int t = 0;
        ack_delay = 10;
        write_run(8'd0, 8'h07);
        while (!o_we0 && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        n_checks++;
        if (t < 10 || t >= 100) $display("FAIL ack_delay: first we after %0d cycles, expected 10..99", t);
        else n_pass++;
        wait_idle("run256");
        ack_delay = 2;
    endtask

    task automatic test_bad_opcodes;
        int h0 = hold_rises;
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'hFF);
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (o_err_cnt !== 8'd3) $display("FAIL err_cnt3: got %0d expected 3", o_err_cnt);
        else n_pass++;
        n_checks++;
        if (hold_rises !== h0 || o_busy !== 1'b0)
            $display("FAIL bad_no_hold: hold rises %0d busy %b, expected %0d and 0", hold_rises, o_busy, h0);
        else n_pass++;
        for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(5, 255)));
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (o_err_cnt !== 8'd255) $display("FAIL err_cnt_sat: got %0d expected 255", o_err_cnt);
        else n_pass++;
    endtask

    task automatic test_clear;
        push_run(16'h0000, 65536, 5'd0);
        send_byte(8'h03);
        wait_idle("clear");
        write_cell(8'h1A);
        wait_idle("clear_cursor");
    endtask

    task automatic test_reset_mid_clear;
        push_run(16'h0000, 65536, 5'd0);
        send_byte(8'h03);
        while (exp_q.size() > 65436 && o_busy) @(negedge i_clk);
        sb_off = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_we0, o_we1, o_hold_req, o_busy, o_in_ready} !== 5'd0)
            $display("FAIL mid_clear_reset: we=%b%b hold=%b busy=%b rdy=%b expected all 0",
                     o_we0, o_we1, o_hold_req, o_busy, o_in_ready);
        else n_pass++;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        sb_off = 1'b0;
        model_cursor = 16'h0000;
        write_cell(8'h09);
        wait_idle("post_reset_cursor");
    endtask

    initial begin
        test_reset();
        test_set_cell();
        test_back_to_back();
        test_run256_delayed();
        test_bad_opcodes();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gol_pattern_loader.md
# gol_pattern_loader

Host-side writer into the Game of Life cell RAM. It parses a byte command stream, such as one from a UART receiver, and writes cell values into both RAM banks through the engine's port-B path while the engine is paused. It is the writer counterpart to the display path, which only reads the banks. A mux in the top level grants it the port-B `addr`/`we0`/`we1`/`din` lines only while `hold_ack` is high.

## Interface
- `ADDR_W`, 16: cell address width. Address is {y[7:0], x[7:0]} for the 256×256 grid.
- `CELL_W`, 5: cell value width. It matches the RAM data width.
- `clk`  in  1  pixel clock; the block has a single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  block can accept a byte. A byte transfers on any edge where `in_valid & in_ready`.
- `hold_req`  out  1  request to pause the engine and take ownership of port B.
- `hold_ack`  in  1  engine paused, port B granted. Once high, it stays high until `hold_req` falls.
- `addr`  out  ADDR_W  write address.
- `we0`, `we1`  out  1  write enables for bank0 and bank1. They are always driven identically.
- `din`  out  CELL_W  write data.
- `busy`  out  1  the FSM is not in IDLE.
- `err_cnt`  out  8  count of unknown opcodes, saturating at 255.

## Operation
- Command set, one opcode byte followed by its argument bytes:
  - 0x01 SET_ADDR x, y: cursor = {y, x}. No write.
  - 0x02 WRITE_RUN n, v: write v[4:0] to n consecutive cells starting at the cursor. n = 0 means 256.
  - 0x03 CLEAR: write 0 to all 65536 cells. The cursor starts at 0 and ends at 0.
  - 0x04 WRITE_CELL v: one write of v[4:0] at the cursor, then cursor + 1.
  - Any other byte received in IDLE: discard it, increment `err_cnt` (saturating), and stay in IDLE.
- Value bytes: bits [7:5] are ignored.
- Cursor: 16 bits, incremented after every write, wrapping 0xFFFF → 0x0000. It is not reset by the end of a command.
- FSM states and transitions:
  - IDLE → ARG1 on 0x01, 0x02 or 0x04.
  - IDLE → REQ on 0x03.
  - ARG1 → ARG2 for 0x01 and 0x02.
  - ARG1 → REQ for 0x04.
  - ARG2 → IDLE for 0x01.
  - ARG2 → REQ for 0x02.
  - REQ → WRITE when `hold_ack` is sampled high.
  - WRITE → IDLE after the last write.
- `in_ready` = 1 in IDLE, ARG1 and ARG2, and 0 in REQ and WRITE. It reads 0 while `rst_n` is low.
- Remaining-count register: 17 bits, loaded with 1, n (0 → 256), or 65536.
- `hold_req` is high from entry into REQ until the cycle after the last write.

## Timing
- All outputs except `in_ready` are registered.
- Reset values: `hold_req` = 0, `we0` = `we1` = 0, `addr` = 0, `din` = 0, `busy` = 0, `err_cnt` = 0, cursor = 0, state = IDLE.
- Final argument byte accepted on edge T: `hold_req` = 1 and `busy` = 1 from T+1.
- `hold_ack` first sampled high on edge E: the first `we0`/`we1` pulse is in the cycle after E, with `addr` = cursor.
- Back-to-back writes follow, one per cycle. An n-cell command produces exactly n consecutive `we` cycles. `addr` increments by 1 each cycle and `din` is constant.
- The last write is in cycle L. `we` = 0, `hold_req` = 0 and `busy` = 0 from L+1. `in_ready` = 1 from L+1.
- Each write command is a single `hold_req` episode with no gaps.
- `hold_ack` already high when REQ is entered: writes still start one cycle after the first sampling edge. There is no combinational path from `hold_ack` to `we`.
- Async reset during WRITE: `we` and `hold_req` go to 0 immediately. The remaining writes are abandoned and the cursor returns to 0.
- `in_valid` held while `in_ready` = 0: the byte is not consumed. It is accepted on the first edge with `in_ready` = 1.
- Throughput: one byte per cycle in IDLE, ARG1 and ARG2.

## Test plan
- Reset: hold `rst_n` low, then release → all outputs 0, `in_ready` = 1 the cycle after release, and the cursor is at 0.
- SET_ADDR 0x10, 0x20, then WRITE_CELL 0x1F with `hold_ack` tied high → exactly one `we0` = `we1` = 1 cycle with `addr` = 0x2010 and `din` = 0x1F. `hold_req` falls the next cycle.
- SET_ADDR 0xFE, 0xFF, then WRITE_RUN 4, 0x03 → 4 consecutive writes to `addr` = 0xFFFE, 0xFFFF, 0x0000, 0x0001. The cursor then reads 0x0002.
- WRITE_RUN 0, 0x07 with `hold_ack` delayed 10 cycles → no `we` during the delay. Then 256 contiguous writes, with `in_ready` = 0 throughout.
- CLEAR → 65536 contiguous writes of 0, `addr` 0x0000 through 0xFFFF. `busy` falls after the last write.
- Bytes 0x00, 0x55, 0xFF in IDLE → `err_cnt` = 3 and no `hold_req`. 300 bad bytes → `err_cnt` = 255. Asserting `rst_n` low mid-CLEAR → `we` = 0 immediately.
